// File: rtl/srl_fifo_pkg.sv
// Shared types and helpers for the SRL FIFO: count-width function and the
// occupancy update encoding used by the control logic.
package srl_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_WRRD = 2'b11
  } fifo_op_e;

  // Bits needed to hold an occupancy of 0..cap inclusive.
  function automatic int calc_cw(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/srl_fifo_v2_storage.sv
// Shift-register storage: new data enters at index 0, older entries move up.
// No reset and no flags, so it maps onto SRL primitives.
module srl_fifo_v2_storage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Explicit compare-select keeps the read legal when DEPTH < 2**ADDR_WIDTH.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) dout = mem[i];
    end
  end

endmodule

// File: rtl/srl_fifo_v2.sv
// SRL-based FIFO with registered count/full/empty/almost-full flags and an
// optional registered output stage (OUT_REG=1 adds one entry of capacity).
module srl_fifo_v2
  import srl_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 4,
  parameter  int DEPTH      = 16,
  parameter  int OUT_REG    = 0,
  parameter  int AF_THRESH  = 14,
  localparam int CAP        = DEPTH + OUT_REG,
  localparam int CW         = calc_cw(CAP)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [CW-1:0]         if_count
);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("srl_fifo_v2: DEPTH must be in 2..2**ADDR_WIDTH");
  end
  if (AF_THRESH < 1 || AF_THRESH > CAP) begin : g_bad_af
    $error("srl_fifo_v2: AF_THRESH must be in 1..CAP");
  end

  // Handshake: a write transfers when if_write & if_write_ce & if_full_n,
  // a read when if_read & if_read_ce & if_empty_n; flags are the registered
  // pre-edge values, so a full FIFO refuses a write even if it is read.
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  srl_pop;
  logic                  out_valid_next;
  logic [CW-1:0]         srl_cnt;
  logic [CW-1:0]         srl_next;
  logic [CW-1:0]         count_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] srl_dout;
  fifo_op_e              op;

  assign wr_acc = if_write & if_write_ce & if_full_n & ~reset;
  assign rd_acc = if_read & if_read_ce & if_empty_n & ~reset;
  assign ptr    = ADDR_WIDTH'(srl_cnt - CW'(1));

  srl_fifo_v2_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk  (clk),
    .we   (wr_acc),
    .addr (ptr),
    .din  (if_din),
    .dout (srl_dout)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic                  out_valid;
    logic                  load_out;
    logic [DATA_WIDTH-1:0] out_reg;

    // Refill the output register whenever it is empty or being consumed.
    assign load_out = (srl_cnt != '0) & (~out_valid | rd_acc) & ~reset;
    assign srl_pop  = load_out;
    assign if_dout  = out_reg;

    always_comb begin
      out_valid_next = out_valid;
      if (load_out)    out_valid_next = 1'b1;
      else if (rd_acc) out_valid_next = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        out_valid <= 1'b0;
        out_reg   <= '0;
      end else begin
        out_valid <= out_valid_next;
        if (load_out) out_reg <= srl_dout;
      end
    end
  end else begin : g_direct
    assign srl_pop        = rd_acc;
    assign out_valid_next = 1'b0;
    assign if_dout        = srl_dout;
  end

  always_comb begin
    op = fifo_op_e'({srl_pop, wr_acc});
    case (op)
      OP_WR:   srl_next = srl_cnt + CW'(1);
      OP_RD:   srl_next = srl_cnt - CW'(1);
      default: srl_next = srl_cnt;
    endcase
    count_next = srl_next + CW'(out_valid_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      srl_cnt        <= '0;
      if_count       <= '0;
      if_full_n      <= 1'b1;
      if_empty_n     <= 1'b0;
      if_almost_full <= 1'b0;
    end else begin
      srl_cnt        <= srl_next;
      if_count       <= count_next;
      if_full_n      <= (count_next < CW'(CAP));
      if_empty_n     <= (OUT_REG != 0) ? out_valid_next : (count_next != '0);
      if_almost_full <= (count_next >= CW'(AF_THRESH));
    end
  end

  a_count_range : assert property (@(posedge clk) disable iff (reset)
    (if_count <= CW'(CAP)) && (srl_cnt <= CW'(DEPTH)));

endmodule

// File: tb/tb_srl_fifo_v2.sv
// Bench for srl_fifo_v2: instance A (DEPTH=4, direct output, AF=3) and
// instance B (DEPTH=4, registered output, AF=4), scoreboarded reads.
module tb_srl_fifo_v2;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic         a_write_ce, a_write, a_read_ce, a_read;
  logic [W-1:0] a_din, a_dout;
  logic         a_full_n, a_af, a_empty_n;
  logic [2:0]   a_count;

  srl_fifo_v2 #(
    .DATA_WIDTH (W), .ADDR_WIDTH (2), .DEPTH (4), .OUT_REG (0), .AF_THRESH (3)
  ) u_a (
    .clk            (clk),
    .reset          (reset),
    .if_write_ce    (a_write_ce),
    .if_write       (a_write),
    .if_din         (a_din),
    .if_full_n      (a_full_n),
    .if_almost_full (a_af),
    .if_read_ce     (a_read_ce),
    .if_read        (a_read),
    .if_dout        (a_dout),
    .if_empty_n     (a_empty_n),
    .if_count       (a_count)
  );

  // ---------------- instance B ----------------
  logic         b_write_ce, b_write, b_read_ce, b_read;
  logic [W-1:0] b_din, b_dout;
  logic         b_full_n, b_af, b_empty_n;
  logic [2:0]   b_count;

  srl_fifo_v2 #(
    .DATA_WIDTH (W), .ADDR_WIDTH (3), .DEPTH (4), .OUT_REG (1), .AF_THRESH (4)
  ) u_b (
    .clk            (clk),
    .reset          (reset),
    .if_write_ce    (b_write_ce),
    .if_write       (b_write),
    .if_din         (b_din),
    .if_full_n      (b_full_n),
    .if_almost_full (b_af),
    .if_read_ce     (b_read_ce),
    .if_read        (b_read),
    .if_dout        (b_dout),
    .if_empty_n     (b_empty_n),
    .if_count       (b_count)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] a_exp_q[$];
  logic [W-1:0] b_exp_q[$];
  int a_mcnt = 0;
  int b_mcnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read pops the oldest expected word.
  always @(negedge clk) begin
    if (!reset && a_read && a_read_ce && a_empty_n) begin
      if (a_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_pop: got 0x%0h expected no data", a_dout);
      end else begin
        check("a_dout_pop", int'(a_dout), int'(a_exp_q.pop_front()));
      end
    end
    if (!reset && b_read && b_read_ce && b_empty_n) begin
      if (b_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_pop: got 0x%0h expected no data", b_dout);
      end else begin
        check("b_dout_pop", int'(b_dout), int'(b_exp_q.pop_front()));
      end
    end
  end

  // ---------------- drivers ----------------
  // Inputs are applied 1 time unit after a rising edge and held for one cycle.
  task automatic a_step(input logic wr, input logic [W-1:0] din, input logic rd);
    logic wacc, racc;
    wacc = wr && (a_mcnt < 4);
    racc = rd && (a_mcnt > 0);
    a_write = wr; a_din = din; a_read = rd;
    if (wacc) a_exp_q.push_back(din);
    @(posedge clk); #1;
    a_mcnt = a_mcnt + int'(wacc) - int'(racc);
    a_write = 1'b0; a_read = 1'b0;
  endtask

  task automatic b_step(input logic wr, input logic [W-1:0] din, input logic rd);
    logic wacc, racc;
    wacc = wr && (b_mcnt < 5);
    racc = rd && (b_mcnt > 0);
    b_write = wr; b_din = din; b_read = rd;
    if (wacc) b_exp_q.push_back(din);
    @(posedge clk); #1;
    b_mcnt = b_mcnt + int'(wacc) - int'(racc);
    b_write = 1'b0; b_read = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    a_write_ce = 1'b1; a_read_ce = 1'b1; a_write = 1'b0; a_read = 1'b0; a_din = '0;
    b_write_ce = 1'b1; b_read_ce = 1'b1; b_write = 1'b0; b_read = 1'b0; b_din = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("a_reset_count", a_count, 0);
    check("a_reset_empty_n", a_empty_n, 0);
    check("a_reset_full_n", a_full_n, 1);
    check("a_reset_af", a_af, 0);
    check("b_reset_count", b_count, 0);
    check("b_reset_empty_n", b_empty_n, 0);
    check("b_reset_full_n", b_full_n, 1);
    check("b_reset_af", b_af, 0);

    // Fill A to capacity, then a dropped write.
    a_step(1'b1, 8'hA1, 1'b0);
    check("a_fill1_count", a_count, 1);
    check("a_fill1_empty_n", a_empty_n, 1);
    a_step(1'b1, 8'hA2, 1'b0);
    a_step(1'b1, 8'hA3, 1'b0);
    check("a_fill3_count", a_count, 3);
    check("a_fill3_af", a_af, 1);
    a_step(1'b1, 8'hA4, 1'b0);
    check("a_fill4_count", a_count, 4);
    check("a_fill4_full_n", a_full_n, 0);
    a_step(1'b1, 8'hA5, 1'b0);
    check("a_drop_count", a_count, 4);
    check("a_drop_full_n", a_full_n, 0);

    // Full with write+read: only the read is taken.
    a_step(1'b1, 8'hB0, 1'b1);
    check("a_fullwr_count", a_count, 3);
    check("a_fullwr_full_n", a_full_n, 1);
    repeat (3) a_step(1'b0, 8'h00, 1'b1);
    check("a_drain_count", a_count, 0);
    check("a_drain_empty_n", a_empty_n, 0);

    // Empty with write+read: only the write is taken; then streaming.
    a_step(1'b1, 8'h55, 1'b1);
    check("a_emptywr_count", a_count, 1);
    check("a_emptywr_dout", a_dout, 8'h55);
    for (int i = 0; i < 8; i++) begin
      a_step(1'b1, W'(8'h60 + i), 1'b1);
      check("a_stream_count", a_count, 1);
    end
    a_step(1'b0, 8'h00, 1'b1);
    check("a_stream_end_count", a_count, 0);

    // Almost-full rises at count 3 and falls at count 2.
    a_step(1'b1, 8'hC1, 1'b0);
    a_step(1'b1, 8'hC2, 1'b0);
    check("a_af2_count", a_count, 2);
    check("a_af2_af", a_af, 0);
    a_step(1'b1, 8'hC3, 1'b0);
    check("a_af3_af", a_af, 1);
    a_step(1'b0, 8'h00, 1'b1);
    check("a_af_fall_count", a_count, 2);
    check("a_af_fall_af", a_af, 0);

    // Reset at count 3 with a simultaneous write discards everything.
    a_step(1'b1, 8'hC4, 1'b0);
    check("a_prerst_count", a_count, 3);
    reset = 1'b1; a_write = 1'b1; a_din = 8'hEE;
    @(posedge clk); #1;
    reset = 1'b0; a_write = 1'b0;
    a_exp_q.delete();
    a_mcnt = 0;
    check("a_rst_count", a_count, 0);
    check("a_rst_empty_n", a_empty_n, 0);
    check("a_rst_full_n", a_full_n, 1);
    check("a_rst_af", a_af, 0);
    a_step(1'b1, 8'h77, 1'b0);
    check("a_post_rst_empty_n", a_empty_n, 1);
    check("a_post_rst_dout", a_dout, 8'h77);
    a_step(1'b0, 8'h00, 1'b1);
    check("a_post_rst_count", a_count, 0);

    // B: two-cycle write-to-empty_n latency through the output register.
    b_step(1'b1, 8'h10, 1'b0);
    check("b_lat1_empty_n", b_empty_n, 0);
    check("b_lat1_count", b_count, 1);
    b_step(1'b0, 8'h00, 1'b0);
    check("b_lat2_empty_n", b_empty_n, 1);
    check("b_lat2_dout", b_dout, 8'h10);
    check("b_lat2_count", b_count, 1);
    b_step(1'b1, 8'h11, 1'b0);
    b_step(1'b1, 8'h12, 1'b0);
    check("b_fill3_count", b_count, 3);
    check("b_fill3_af", b_af, 0);
    b_step(1'b1, 8'h13, 1'b0);
    check("b_fill4_af", b_af, 1);
    b_step(1'b1, 8'h14, 1'b0);
    check("b_fill5_count", b_count, 5);
    check("b_fill5_full_n", b_full_n, 0);
    b_step(1'b1, 8'h15, 1'b0);
    check("b_drop_count", b_count, 5);

    // Drain with read held: one word per cycle, no bubble.
    for (int i = 0; i < 5; i++) begin
      b_step(1'b0, 8'h00, 1'b1);
      check("b_drain_count", b_count, 4 - i);
      check("b_drain_empty_n", b_empty_n, (i < 4) ? 1 : 0);
    end

    repeat (2) @(posedge clk);
    check("a_queue_left", a_exp_q.size(), 0);
    check("b_queue_left", b_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
